launch_sequencer: RTL and testbench
===================================

# launch_sequencer

Top-level countdown controller for the rocket launch program. It consumes the 1 Hz one-cycle tick from the clock divider and debounced operator inputs (arm switch, launch and abort buttons). It sequences IDLE → ARMED → COUNT → IGNITE → LIFTOFF, with an ABORT path. It drives the BCD countdown digits for the 7-segment driver and the igniter, liftoff and abort indicators.

## Interface

- COUNT_START, 10, countdown start value in seconds; legal 1..99
- IGNITE_SECS, 2, number of ticks spent in IGNITE before LIFTOFF; legal 1..15
- ABORT_SECS, 5, minimum number of ticks held in ABORT; legal 1..15

- clk  in  1  12 MHz system clock
- rst_n  in  1  asynchronous, active-low reset
- tick_1hz  in  1  one-cycle pulse, once per second, synchronous to clk
- arm_sw  in  1  arm switch level, already synchronized
- launch_btn  in  1  one-cycle pulse, already debounced
- abort_btn  in  1  one-cycle pulse, already debounced
- state  out  3  IDLE=0, ARMED=1, COUNT=2, IGNITE=3, LIFTOFF=4, ABORT=5
- count_tens  out  4  BCD tens digit of the remaining seconds
- count_ones  out  4  BCD ones digit of the remaining seconds
- igniter  out  1  high while in IGNITE
- liftoff  out  1  high while in LIFTOFF
- abort_led  out  1  high while in ABORT
- beep  out  1  one-cycle pulse on each countdown decrement

## Operation

- **Reset values:** state=IDLE, count=COUNT_START in BCD, sec_cnt=0; igniter, liftoff, abort_led and beep all 0.
- **Counters:**
  - count is held as two BCD digits and decrements with borrow (e.g. 10 → 09, 20 → 19).
  - sec_cnt is a 4-bit tick counter used by IGNITE and ABORT.
- **Input priority within one cycle:** abort_btn > arm_sw low > tick_1hz > launch_btn.
- **IDLE:** count held at COUNT_START. arm_sw=1 → ARMED.
- **ARMED:**
  - arm_sw=0 → IDLE.
  - launch_btn → COUNT; count stays at COUNT_START.
  - abort_btn → ABORT.
- **COUNT:**
  - abort_btn, or arm_sw=0 → ABORT.
  - On tick with count > 1: count decrements and beep pulses.
  - On tick with count == 1: count becomes 00, beep pulses, state → IGNITE, sec_cnt cleared.
- **IGNITE:**
  - igniter=1.
  - abort_btn, or arm_sw=0 → ABORT; igniter drops in the same cycle the state changes.
  - Each tick increments sec_cnt. When sec_cnt reaches IGNITE_SECS → LIFTOFF.
- **LIFTOFF:**
  - liftoff=1; count remains 00.
  - abort_btn is ignored.
  - arm_sw=0 → IDLE, and count reloads COUNT_START.
- **ABORT:**
  - abort_led=1; sec_cnt is cleared on entry; count is frozen at its value on entry.
  - Each tick increments sec_cnt.
  - Once sec_cnt == ABORT_SECS and arm_sw=0 → IDLE, and count reloads.
  - If arm_sw is still high, the block stays in ABORT until the switch is lowered. This forces a full re-arm.
  - abort_btn while already in ABORT is ignored and does not restart the hold.
- **Ignored inputs:** launch_btn outside ARMED has no effect. tick_1hz in IDLE, ARMED or LIFTOFF has no effect.

## Timing

- All outputs are registered or decoded from registered state only. There is no combinational path from any input to any output.
- An input event sampled at edge N is visible on state, count and indicators after edge N (cycle N+1).
- beep is high for exactly the one cycle after the tick that decremented count.
- launch_btn and tick_1hz in the same cycle while ARMED: enter COUNT without decrementing. The first decrement happens on the next tick.
- **Countdown length:** the first tick after launch takes count to COUNT_START-1. IGNITE is entered on the COUNT_START-th tick after launch. LIFTOFF follows IGNITE_SECS ticks later.
- **Mid-operation reset:** rst_n low immediately forces the reset values, independent of clk, including dropping igniter.
- Reset deassertion is assumed synchronized upstream. The first edge after deassertion evaluates IDLE.

## Test plan

Tick is driven every 10 cycles in the bench. Parameters are COUNT_START=10, IGNITE_SECS=2, ABORT_SECS=5.

1. Assert rst_n=0 mid-IGNITE, between edges → igniter=0, state=0 and count=10 immediately; no clk edge required.
2. Nominal launch: arm, launch, run 12 ticks →
   - count sequence 10, 09, …, 01, 00 with 10 beep pulses;
   - igniter high for exactly 2 tick periods;
   - state=4 and liftoff=1 after tick 12.
3. Abort at count 04 →
   - state=5, count frozen at 04, abort_led=1;
   - with arm_sw held high through 7 ticks, state stays 5;
   - lower arm_sw → state=0, count=10.
4. arm_sw dropped during IGNITE → ABORT the next cycle with igniter=0. Then 5 ticks with arm_sw=0 → IDLE.
5. Edge cases:
   - launch_btn and tick in the same cycle in ARMED → state=2, count stays 10.
   - launch_btn in IDLE → no change.
   - abort_btn and tick in the same cycle in COUNT → ABORT with no decrement and no beep.
6. BCD borrow with COUNT_START=20 → count steps 20 → 19 and 10 → 09. Never shows 1F or 0F.

Source files
------------

// File: rtl/launch_sequencer.sv
// launch_sequencer: countdown controller for the launch program.
// Sequences IDLE -> ARMED -> COUNT -> IGNITE -> LIFTOFF, with an ABORT path.
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   tick_1hz            one-cycle 1 Hz tick
//   arm_sw              arm switch level
//   launch_btn          one-cycle launch pulse
//   abort_btn           one-cycle abort pulse
//   state               current state code (IDLE=0 .. ABORT=5)
//   count_tens/ones     BCD remaining seconds
//   igniter             high in IGNITE
//   liftoff             high in LIFTOFF
//   abort_led           high in ABORT
//   beep                one-cycle pulse per countdown decrement
module launch_sequencer #(
  parameter int unsigned COUNT_START = 10,
  parameter int unsigned IGNITE_SECS = 2,
  parameter int unsigned ABORT_SECS  = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       arm_sw,
  input  logic       launch_btn,
  input  logic       abort_btn,
  output logic [2:0] state,
  output logic [3:0] count_tens,
  output logic [3:0] count_ones,
  output logic       igniter,
  output logic       liftoff,
  output logic       abort_led,
  output logic       beep
);

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned SEC_W   = 4;

  localparam logic [DIGIT_W-1:0] TENS_INIT  = DIGIT_W'(COUNT_START / 10);
  localparam logic [DIGIT_W-1:0] ONES_INIT  = DIGIT_W'(COUNT_START % 10);
  localparam logic [SEC_W-1:0]   IGNITE_END = SEC_W'(IGNITE_SECS);
  localparam logic [SEC_W-1:0]   ABORT_END  = SEC_W'(ABORT_SECS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_COUNT   = 3'd2,
    S_IGNITE  = 3'd3,
    S_LIFTOFF = 3'd4,
    S_ABORT   = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [DIGIT_W-1:0] r_tens;
  logic [DIGIT_W-1:0] r_ones;
  logic [DIGIT_W-1:0] w_tens_nxt;
  logic [DIGIT_W-1:0] w_ones_nxt;
  logic [SEC_W-1:0]   r_sec_cnt;
  logic [SEC_W-1:0]   w_sec_nxt;
  logic               w_beep_nxt;
  logic               w_count_is_one;
  logic               r_igniter;
  logic               r_liftoff;
  logic               r_abort_led;
  logic               r_beep;

  assign w_count_is_one = (r_tens == '0) && (r_ones == DIGIT_W'(1));

  // State, counters and indicator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_tens      <= TENS_INIT;
      r_ones      <= ONES_INIT;
      r_sec_cnt   <= '0;
      r_igniter   <= 1'b0;
      r_liftoff   <= 1'b0;
      r_abort_led <= 1'b0;
      r_beep      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_tens      <= w_tens_nxt;
      r_ones      <= w_ones_nxt;
      r_sec_cnt   <= w_sec_nxt;
      // Indicators follow the next state so they change on the same edge.
      r_igniter   <= (w_state_nxt == S_IGNITE);
      r_liftoff   <= (w_state_nxt == S_LIFTOFF);
      r_abort_led <= (w_state_nxt == S_ABORT);
      r_beep      <= w_beep_nxt;
    end
  end

  // Next-state and counter logic; priority abort > arm low > tick > launch.
  always_comb begin
    w_state_nxt = r_state;
    w_tens_nxt  = r_tens;
    w_ones_nxt  = r_ones;
    w_sec_nxt   = r_sec_cnt;
    w_beep_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_tens_nxt = TENS_INIT;
        w_ones_nxt = ONES_INIT;
        if (arm_sw) begin
          w_state_nxt = S_ARMED;
        end
      end

      S_ARMED: begin
        if (abort_btn) begin
          w_state_nxt = S_ABORT;
          w_sec_nxt   = '0;
        end else if (!arm_sw) begin
          w_state_nxt = S_IDLE;
        end else if (launch_btn) begin
          // A coincident tick is deliberately not counted here.
          w_state_nxt = S_COUNT;
        end
      end

      S_COUNT: begin
        if (abort_btn || !arm_sw) begin
          w_state_nxt = S_ABORT;
          w_sec_nxt   = '0;
        end else if (tick_1hz) begin
          w_beep_nxt = 1'b1;
          if (w_count_is_one) begin
            w_ones_nxt  = '0;
            w_state_nxt = S_IGNITE;
            w_sec_nxt   = '0;
          end else if (r_ones == '0) begin
            // BCD borrow from the tens digit.
            w_ones_nxt = DIGIT_W'(9);
            w_tens_nxt = r_tens - DIGIT_W'(1);
          end else begin
            w_ones_nxt = r_ones - DIGIT_W'(1);
          end
        end
      end

      S_IGNITE: begin
        if (abort_btn || !arm_sw) begin
          w_state_nxt = S_ABORT;
          w_sec_nxt   = '0;
        end else if (tick_1hz) begin
          w_sec_nxt = r_sec_cnt + SEC_W'(1);
          if ((r_sec_cnt + SEC_W'(1)) == IGNITE_END) begin
            w_state_nxt = S_LIFTOFF;
          end
        end
      end

      S_LIFTOFF: begin
        if (!arm_sw) begin
          w_state_nxt = S_IDLE;
          w_tens_nxt  = TENS_INIT;
          w_ones_nxt  = ONES_INIT;
        end
      end

      S_ABORT: begin
        // Hold counter saturates at the minimum hold; a second abort is ignored.
        if (r_sec_cnt == ABORT_END) begin
          if (!arm_sw) begin
            w_state_nxt = S_IDLE;
            w_tens_nxt  = TENS_INIT;
            w_ones_nxt  = ONES_INIT;
          end
        end else if (tick_1hz) begin
          w_sec_nxt = r_sec_cnt + SEC_W'(1);
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign state      = r_state;
  assign count_tens = r_tens;
  assign count_ones = r_ones;
  assign igniter    = r_igniter;
  assign liftoff    = r_liftoff;
  assign abort_led  = r_abort_led;
  assign beep       = r_beep;

endmodule

// File: tb/tb_launch_sequencer.sv
// Testbench for launch_sequencer: vector table plus directed multi-cycle sequences.
module tb_launch_sequencer;

  logic       clk;
  logic       rst_n;
  logic       tick_1hz;
  logic       arm_sw;
  logic       launch_btn;
  logic       abort_btn;
  logic [2:0] state;
  logic [3:0] count_tens;
  logic [3:0] count_ones;
  logic       igniter;
  logic       liftoff;
  logic       abort_led;
  logic       beep;

  logic [2:0] state_b;
  logic [3:0] tens_b;
  logic [3:0] ones_b;
  logic       igniter_b;
  logic       liftoff_b;
  logic       abort_led_b;
  logic       beep_b;

  int n_checks = 0;
  int n_errors = 0;

  launch_sequencer #(.COUNT_START(10), .IGNITE_SECS(2), .ABORT_SECS(5)) dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .arm_sw(arm_sw),
    .launch_btn(launch_btn), .abort_btn(abort_btn), .state(state),
    .count_tens(count_tens), .count_ones(count_ones), .igniter(igniter),
    .liftoff(liftoff), .abort_led(abort_led), .beep(beep)
  );

  launch_sequencer #(.COUNT_START(20), .IGNITE_SECS(2), .ABORT_SECS(5)) dut20 (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .arm_sw(arm_sw),
    .launch_btn(launch_btn), .abort_btn(abort_btn), .state(state_b),
    .count_tens(tens_b), .count_ones(ones_b), .igniter(igniter_b),
    .liftoff(liftoff_b), .abort_led(abort_led_b), .beep(beep_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       arm;
    logic       launch;
    logic       abrt;
    logic       tick;
    logic [2:0] st;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       bp;
    logic       ign;
    logic       lift;
    logic       aled;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock cycle with the given inputs; returns #1 after the edge.
  task automatic cycle(input logic a, input logic l, input logic ab, input logic t);
    arm_sw = a; launch_btn = l; abort_btn = ab; tick_1hz = t;
    @(posedge clk); #1;
    launch_btn = 1'b0; abort_btn = 1'b0; tick_1hz = 1'b0;
  endtask

  // Nine quiet cycles then one tick cycle.
  task automatic tick_period(input logic a);
    for (int i = 0; i < 9; i++) cycle(a, 1'b0, 1'b0, 1'b0);
    cycle(a, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    arm_sw = 1'b0; launch_btn = 1'b0; abort_btn = 1'b0; tick_1hz = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int beeps;
    int ign_cycles;
    int val;

    rst_n = 1'b0; arm_sw = 1'b0; launch_btn = 1'b0; abort_btn = 1'b0; tick_1hz = 1'b0;

    //                arm  lau  abt  tck  st    tens  ones  beep ign  lift aled
    vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 4'd0, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 4'd0, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 3'd5, 4'd0, 4'd9, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd5, 4'd0, 4'd9, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 4'd0, 4'd9, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[9] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd5, 4'd0, 4'd9, 1'b0, 1'b0, 1'b0, 1'b1};

    #12;
    check("rst_state", int'(state), 0);
    check("rst_tens", int'(count_tens), 1);
    check("rst_ones", int'(count_ones), 0);
    check("rst_ind", int'({igniter, liftoff, abort_led, beep}), 0);
    check("rst_tens20", int'(tens_b), 2);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Edge-case vector table.
    for (int i = 0; i < 10; i++) begin
      cycle(vecs[i].arm, vecs[i].launch, vecs[i].abrt, vecs[i].tick);
      check($sformatf("v%0d_state", i), int'(state), int'(vecs[i].st));
      check($sformatf("v%0d_tens", i), int'(count_tens), int'(vecs[i].tens));
      check($sformatf("v%0d_ones", i), int'(count_ones), int'(vecs[i].ones));
      check($sformatf("v%0d_beep", i), int'(beep), int'(vecs[i].bp));
      check($sformatf("v%0d_ign", i), int'(igniter), int'(vecs[i].ign));
      check($sformatf("v%0d_lift", i), int'(liftoff), int'(vecs[i].lift));
      check($sformatf("v%0d_aled", i), int'(abort_led), int'(vecs[i].aled));
    end

    // Nominal launch: 12 ticks.
    do_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    check("nom_launch_state", int'(state), 2);
    beeps = 0; ign_cycles = 0;
    for (int k = 1; k <= 12; k++) begin
      for (int i = 0; i < 9; i++) begin
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        beeps += int'(beep); ign_cycles += int'(igniter);
      end
      cycle(1'b1, 1'b0, 1'b0, 1'b1);
      beeps += int'(beep); ign_cycles += int'(igniter);
      val = (k >= 10) ? 0 : 10 - k;
      check($sformatf("nom_t%0d_tens", k), int'(count_tens), val / 10);
      check($sformatf("nom_t%0d_ones", k), int'(count_ones), val % 10);
      check($sformatf("nom_t%0d_state", k), int'(state), (k < 10) ? 2 : (k < 12) ? 3 : 4);
    end
    check("nom_beeps", beeps, 10);
    check("nom_ign_cycles", ign_cycles, 20);
    check("nom_liftoff", int'(liftoff), 1);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    check("lift_abort_ignored", int'(state), 4);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("lift_disarm_state", int'(state), 0);
    check("lift_disarm_tens", int'(count_tens), 1);

    // Asynchronous reset in the middle of IGNITE.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) tick_period(1'b1);
    check("ign_before_rst", int'(igniter), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_igniter", int'(igniter), 0);
    check("arst_state", int'(state), 0);
    check("arst_tens", int'(count_tens), 1);
    check("arst_ones", int'(count_ones), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Abort at 04 with the arm switch held high.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) tick_period(1'b1);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    check("ab4_state", int'(state), 5);
    check("ab4_ones", int'(count_ones), 4);
    check("ab4_led", int'(abort_led), 1);
    for (int k = 0; k < 7; k++) tick_period(1'b1);
    check("ab4_hold_state", int'(state), 5);
    check("ab4_hold_ones", int'(count_ones), 4);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("ab4_exit_state", int'(state), 0);
    check("ab4_exit_tens", int'(count_tens), 1);
    check("ab4_exit_ones", int'(count_ones), 0);

    // Arm switch dropped during IGNITE.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) tick_period(1'b1);
    check("ign_state", int'(state), 3);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("igdrop_state", int'(state), 5);
    check("igdrop_igniter", int'(igniter), 0);
    check("igdrop_led", int'(abort_led), 1);
    for (int k = 0; k < 4; k++) tick_period(1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("igdrop_4ticks_state", int'(state), 5);
    tick_period(1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("igdrop_exit_state", int'(state), 0);
    check("igdrop_exit_tens", int'(count_tens), 1);

    // BCD borrow with a start value of 20.
    do_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    check("c20_start_tens", int'(tens_b), 2);
    for (int k = 1; k <= 11; k++) begin
      tick_period(1'b1);
      val = 20 - k;
      check($sformatf("c20_t%0d_tens", k), int'(tens_b), val / 10);
      check($sformatf("c20_t%0d_ones", k), int'(ones_b), val % 10);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
